// File: rtl/dac_pulse_seq.sv
// Programming-pulse sequencer for the memristor array DAC: drive, hold and read phases.
// Optional completion counter output seq_cnt is enabled by defining DAC_PULSE_SEQ_CNT_EN.
module dac_pulse_seq #(
  parameter int unsigned          DAC_W     = 12,
  parameter int unsigned          CNT_W     = 16,
  parameter int unsigned          T1        = 100,
  parameter int unsigned          T2        = 100,
  parameter int unsigned          T_READ    = 20,
  parameter logic [DAC_W-1:0]     V0_CODE   = 12'h800,
  parameter logic [DAC_W-1:0]     SET_V1    = 12'hC00,
  parameter logic [DAC_W-1:0]     SET_V2    = 12'hA00,
  parameter logic [DAC_W-1:0]     RST_V1    = 12'h400,
  parameter logic [DAC_W-1:0]     RST_V2    = 12'h600,
  parameter logic [DAC_W-1:0]     READ_CODE = 12'h880
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       system_state,
  input  logic             key_state,
  input  logic             start,
  output logic [3:0]       dac_top_state,
  output logic [DAC_W-1:0] dac_code,
  output logic             dac_wr,
  output logic             busy,
  output logic             done
`ifdef DAC_PULSE_SEQ_CNT_EN
  ,
  output logic [15:0]      seq_cnt
`endif
);

  localparam int unsigned SEQ_CNT_W = 16;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    V1_2     = 4'd1,
    CNT_1_2  = 4'd2,
    V2_2     = 4'd3,
    CNT_2_2  = 4'd4,
    V_READ   = 4'd5,
    COMPLETE = 4'd6,
    V1_1     = 4'd7,
    V2_1     = 4'd8,
    CNT_1_1  = 4'd9,
    CNT_2_1  = 4'd10
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DAC_W-1:0]   code_d;
  logic               wr_d, done_d, busy_d;
  logic               mode_rst_q, mode_rst_d;
  logic               accept_c;
  logic               cnt_zero_c;

  assign accept_c   = start && key_state &&
                      ((system_state == 3'd2) || (system_state == 3'd3));
  assign cnt_zero_c = (cnt_q == '0);

  // State, counter and registered outputs all update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mode_rst_q <= 1'b0;
      dac_code   <= V0_CODE;
      dac_wr     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_rst_q <= mode_rst_d;
      dac_code   <= code_d;
      dac_wr     <= wr_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  assign dac_top_state = 4'(state_q);

  // Next-state, counter and output decode; abort overrides every advance.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_rst_d = mode_rst_q;
    code_d     = dac_code;
    wr_d       = 1'b0;
    done_d     = 1'b0;

    if ((state_q != IDLE) && !key_state) begin
      state_d = IDLE;
      cnt_d   = '0;
      code_d  = V0_CODE;
      wr_d    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            mode_rst_d = (system_state == 3'd3);
            state_d    = (system_state == 3'd3) ? V1_1 : V1_2;
            code_d     = (system_state == 3'd3) ? RST_V1 : SET_V1;
            wr_d       = 1'b1;
          end
        end
        V1_2, V1_1: begin
          state_d = mode_rst_q ? CNT_1_1 : CNT_1_2;
          cnt_d   = CNT_W'(T1 - 1);
        end
        CNT_1_2, CNT_1_1: begin
          if (cnt_zero_c) begin
            state_d = mode_rst_q ? V2_1 : V2_2;
            code_d  = mode_rst_q ? RST_V2 : SET_V2;
            wr_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        V2_2, V2_1: begin
          state_d = mode_rst_q ? CNT_2_1 : CNT_2_2;
          cnt_d   = CNT_W'(T2 - 1);
        end
        CNT_2_2, CNT_2_1: begin
          if (cnt_zero_c) begin
            state_d = V_READ;
            cnt_d   = CNT_W'(T_READ - 1);
            code_d  = READ_CODE;
            wr_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        V_READ: begin
          if (cnt_zero_c) begin
            state_d = COMPLETE;
            code_d  = V0_CODE;
            wr_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        COMPLETE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          code_d  = V0_CODE;
          wr_d    = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

`ifdef DAC_PULSE_SEQ_CNT_EN
  // Saturating count of completed sequences; aborts never reach COMPLETE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_cnt <= '0;
    end else if (done_d && (seq_cnt != {SEQ_CNT_W{1'b1}})) begin
      seq_cnt <= seq_cnt + SEQ_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dac_pulse_seq.sv
// Table-driven directed bench for dac_pulse_seq with T1=4, T2=3, T_READ=2.
`timescale 1ns/1ps
module tb_dac_pulse_seq;

  localparam int unsigned T1     = 4;
  localparam int unsigned T2     = 3;
  localparam int unsigned T_READ = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  system_state;
  logic        key_state;
  logic        start;
  logic [3:0]  dac_top_state;
  logic [11:0] dac_code;
  logic        dac_wr;
  logic        busy;
  logic        done;
`ifdef DAC_PULSE_SEQ_CNT_EN
  logic [15:0] seq_cnt;
`endif

  dac_pulse_seq #(.T1(T1), .T2(T2), .T_READ(T_READ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .system_state (system_state),
    .key_state    (key_state),
    .start        (start),
    .dac_top_state(dac_top_state),
    .dac_code     (dac_code),
    .dac_wr       (dac_wr),
    .busy         (busy),
    .done         (done)
`ifdef DAC_PULSE_SEQ_CNT_EN
    ,
    .seq_cnt      (seq_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        key;
    logic [2:0]  sys;
    logic [3:0]  st;
    logic [11:0] code;
    logic        wr;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   exp_seq = 0;

  task automatic add(input logic s, input logic k, input logic [2:0] sy,
                     input logic [3:0] st, input logic [11:0] c,
                     input logic w, input logic b, input logic d);
    vec_t v;
    v.start = s; v.key = k; v.sys = sy; v.st = st;
    v.code = c; v.wr = w; v.busy = b; v.done = d;
    vq.push_back(v);
  endtask

  // One full sequence; sy_run is driven on system_state after acceptance.
  task automatic add_seq(input logic [2:0] sy, input logic [2:0] sy_run, input logic hold);
    logic [3:0]  sv1, sc1, sv2, sc2;
    logic [11:0] c1, c2;
    if (sy == 3'd3) begin
      sv1 = 4'd7; sc1 = 4'd9; sv2 = 4'd8; sc2 = 4'd10; c1 = 12'h400; c2 = 12'h600;
    end else begin
      sv1 = 4'd1; sc1 = 4'd2; sv2 = 4'd3; sc2 = 4'd4; c1 = 12'hC00; c2 = 12'hA00;
    end
    add(1'b1, 1'b1, sy, sv1, c1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < int'(T1); i++) add(hold, 1'b1, sy_run, sc1, c1, 1'b0, 1'b1, 1'b0);
    add(hold, 1'b1, sy_run, sv2, c2, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < int'(T2); i++) add(hold, 1'b1, sy_run, sc2, c2, 1'b0, 1'b1, 1'b0);
    add(hold, 1'b1, sy_run, 4'd5, 12'h880, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < int'(T_READ); i++) add(hold, 1'b1, sy_run, 4'd5, 12'h880, 1'b0, 1'b1, 1'b0);
    add(hold, 1'b1, sy_run, 4'd6, 12'h800, 1'b1, 1'b1, 1'b1);
    add(hold, 1'b1, sy_run, 4'd0, 12'h800, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_out(input string name, input logic [3:0] st, input logic [11:0] c,
                           input logic w, input logic b, input logic d);
    n_vec++;
    if ({dac_top_state, dac_code, dac_wr, busy, done} !== {st, c, w, b, d}) begin
      n_fail++;
      $display("FAIL %s: got st=%0d code=%h wr=%b busy=%b done=%b, want st=%0d code=%h wr=%b busy=%b done=%b",
               name, dac_top_state, dac_code, dac_wr, busy, done, st, c, w, b, d);
    end
  endtask

`ifdef DAC_PULSE_SEQ_CNT_EN
  task automatic check_seq(input string name, input int want);
    n_vec++;
    if (int'(seq_cnt) != want) begin
      n_fail++;
      $display("FAIL %s: seq_cnt got %0d want %0d", name, seq_cnt, want);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; key_state = 1'b0; system_state = 3'd0;

    // Mode 2 sequence, then mode 3 with system_state changed mid-run.
    add_seq(3'd2, 3'd2, 1'b0);
    add_seq(3'd3, 3'd0, 1'b0);
    // Ignored starts.
    add(1'b1, 1'b0, 3'd2, 4'd0, 12'h800, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 3'd1, 4'd0, 12'h800, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 3'd4, 4'd0, 12'h800, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd2, 4'd0, 12'h800, 1'b0, 1'b0, 1'b0);
    // Abort on the second CNT_2_2 cycle.
    add(1'b1, 1'b1, 3'd2, 4'd1, 12'hC00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < int'(T1); i++) add(1'b0, 1'b1, 3'd2, 4'd2, 12'hC00, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd2, 4'd3, 12'hA00, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd2, 4'd4, 12'hA00, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 3'd2, 4'd4, 12'hA00, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 3'd2, 4'd0, 12'h800, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 3'd2, 4'd0, 12'h800, 1'b0, 1'b0, 1'b0);
    // Start held high through two back-to-back sequences.
    add_seq(3'd2, 3'd2, 1'b1);
    add_seq(3'd2, 3'd2, 1'b1);

    #12;
    check_out("reset", 4'd0, 12'h800, 1'b0, 1'b0, 1'b0);
`ifdef DAC_PULSE_SEQ_CNT_EN
    check_seq("reset_seq_cnt", 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    key_state = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      start = vq[i].start; key_state = vq[i].key; system_state = vq[i].sys;
      @(posedge clk);
      #1;
      if (vq[i].done) exp_seq++;
      check_out($sformatf("vec%0d", i), vq[i].st, vq[i].code, vq[i].wr, vq[i].busy, vq[i].done);
`ifdef DAC_PULSE_SEQ_CNT_EN
      check_seq($sformatf("vec%0d_seq_cnt", i), exp_seq);
`endif
    end

    // Asynchronous reset in the middle of CNT_1_2.
    @(negedge clk);
    start = 1'b1; key_state = 1'b1; system_state = 3'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_out("pre_reset_cnt1", 4'd2, 12'hC00, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 4'd0, 12'h800, 1'b0, 1'b0, 1'b0);
`ifdef DAC_PULSE_SEQ_CNT_EN
    check_seq("async_reset_seq_cnt", 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("post_reset_idle", 4'd0, 12'h800, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_pulse_seq.md
Name: dac_pulse_seq

Overview:
Sequencer that produces the programming-pulse sequence for the memristor array DAC during training. On a start request it steps through the drive, hold and read phases and publishes its state on dac_top_state. The switch controllers decode dac_top_state to route the array lines, so this block is the source end of that state interface. It also emits the DAC code with a load strobe and a done pulse back to the system controller.

Parameters:
DAC_W, 12, DAC code width
CNT_W, 16, hold-counter width
T1, 100, CNT_1_x hold length in cycles (1..2^CNT_W-1)
T2, 100, CNT_2_x hold length in cycles (1..2^CNT_W-1)
T_READ, 20, V_READ hold length in cycles (1..2^CNT_W-1)
V0_CODE, 12'h800, idle/zero-bias code
SET_V1, 12'hC00, first-level code, system_state 2
SET_V2, 12'hA00, second-level code, system_state 2
RST_V1, 12'h400, first-level code, system_state 3
RST_V2, 12'h600, second-level code, system_state 3
READ_CODE, 12'h880, read-bias code

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
system_state  in  3  system mode; 2 = set sequence, 3 = reset sequence
key_state  in  1  enable; low aborts any sequence
start  in  1  sequence request, sampled in IDLE only
dac_top_state  out  4  current state encoding
dac_code  out  DAC_W  registered DAC code
dac_wr  out  1  1-cycle strobe whenever dac_code changes
busy  out  1  high in every non-IDLE state
done  out  1  1-cycle pulse in COMPLETE

Behaviour:
- Reset values: dac_top_state=0 (IDLE), dac_code=V0_CODE, dac_wr=0, busy=0, done=0, counter=0.
- State encodings: IDLE=0, V1_2=1, CNT_1_2=2, V2_2=3, CNT_2_2=4, V_READ=5, COMPLETE=6, V1_1=7, V2_1=8, CNT_1_1=9, CNT_2_1=10. Codes 11-15 are illegal and go to IDLE with V0_CODE and dac_wr=1.
- All outputs are registered and update on the same edge as the state.
- Start from IDLE:
  - Accepted when start=1, key_state=1 and system_state is 2 or 3.
  - Mode is latched at acceptance; later system_state changes are ignored until IDLE.
  - Any other combination is ignored and the block stays in IDLE.
- Mode 2 path: V1_2 (1 cycle) -> CNT_1_2 (T1 cycles) -> V2_2 (1) -> CNT_2_2 (T2) -> V_READ (T_READ) -> COMPLETE (1) -> IDLE.
- Mode 3 path: V1_1 -> CNT_1_1 -> V2_1 -> CNT_2_1 -> V_READ -> COMPLETE -> IDLE, with the same durations.
- Codes and strobes:
  - On entry to V1_x, dac_code=SET_V1 or RST_V1 and dac_wr=1.
  - On entry to V2_x, dac_code=SET_V2 or RST_V2 and dac_wr=1.
  - On entry to V_READ, dac_code=READ_CODE and dac_wr=1.
  - On entry to COMPLETE, dac_code=V0_CODE, dac_wr=1, done=1.
  - CNT states hold dac_code with dac_wr=0.
- Latency: accepted start at edge N gives V1_x at edge N+1. busy lasts 3+T1+T2+T_READ cycles.
- Counter: loads on entry to each timed state, and the state exits after exactly T cycles. The counter never wraps.
- Abort: key_state=0 in any non-IDLE state sends the block to IDLE at the next edge with dac_code=V0_CODE, dac_wr=1, done=0. Abort has priority over normal advance, including in COMPLETE.
- start asserted while busy is ignored; no queuing.
- In the COMPLETE cycle start is ignored. A start in the first IDLE cycle is accepted.
- Reset mid-sequence forces the reset values immediately (asynchronous).

Optional Feature:
Macro DAC_PULSE_SEQ_CNT_EN.
- Defined: adds output seq_cnt [15:0], which increments on each COMPLETE entry, saturates at 16'hFFFF, is not incremented by aborts and is cleared only by rst_n.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
Use T1=4, T2=3, T_READ=2.
- Reset mid-CNT_1_2 -> dac_top_state=0, dac_code=12'h800, dac_wr=0, busy=0 immediately.
- system_state=2, key_state=1, 1-cycle start -> states 1,2x4,3,4x3,5x2,6,0; dac_wr high on 1, 3, 5, 6; codes C00, A00, 880, 800; done only at 6; busy 12 cycles.
- system_state=3, same stimulus -> states 7,9x4,8,10x3,5x2,6,0; codes 400, 600, 880, 800.
- start with key_state=0, or with system_state=1 or 4 -> stays 0; no dac_wr.
- key_state dropped on the 2nd CNT_2_2 cycle -> next state 0, dac_code=800, dac_wr=1, done=0; seq_cnt unchanged.
- start held high continuously through a sequence -> ignored in states 1-6; a new sequence begins one cycle after IDLE is entered; seq_cnt=2 after two completions.
